// File: rtl/dsp_fixed_pkg.sv
// Shared Q12 fixed-point types, constants and helpers for the overdrive path.
// Provides sample/wide types, FSM state enum and truncating divide.
package dsp_fixed_pkg;

  localparam int SAMPLE_W  = 32;
  localparam int FRAC      = 12;
  localparam int ONE       = 2 ** FRAC;
  localparam int CLAMP_OUT = ONE / 2;
  localparam int WIDE_W    = 2 * (SAMPLE_W + 1);

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [WIDE_W-1:0]   wide_t;

  typedef enum logic [2:0] {
    IDLE,
    GAIN,
    SQ,
    CUBE,
    SUM,
    OUT
  } state_t;

  // Sign-magnitude shift so negative values round toward zero.
  function automatic wide_t fx_trunc_div(input wide_t x,
                                         input int unsigned n);
    wide_t m;
    m = x[WIDE_W-1] ? -x : x;
    m = m >> n;
    return x[WIDE_W-1] ? -m : m;
  endfunction

endpackage

// File: rtl/overdrive_seq_if.sv
// Handshake bundle for overdrive_seq: input sample side, output side, clip status.
// master drives samples/out_ready/clip_clr; slave (the DUT) drives the rest.
interface overdrive_seq_if #(
  parameter int DATA_W = 32,
  parameter int GAIN_W = 16,
  parameter int CNT_W  = 16
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_sample;
  logic [GAIN_W-1:0]        gain;
  logic                     bypass;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_sample;
  logic                     clipped;
  logic [CNT_W-1:0]         clip_count;
  logic                     clip_clr;

  modport master (
    output in_valid, in_sample, gain, bypass, out_ready, clip_clr,
    input  in_ready, out_valid, out_sample, clipped, clip_count
  );

  modport slave (
    input  in_valid, in_sample, gain, bypass, out_ready, clip_clr,
    output in_ready, out_valid, out_sample, clipped, clip_count
  );

endinterface

// File: rtl/fx_mult.sv
// Shared combinational Q12 multiplier: p_o = (a_i*b_i)/2^SH, toward zero.
// Ports: a_i, b_i signed operands (muxed by parent); p_o full-width quotient.
module fx_mult #(
  parameter int OPW = 33,
  parameter int SH  = 12
) (
  input  logic signed [OPW-1:0]   a_i,
  input  logic signed [OPW-1:0]   b_i,
  output logic signed [2*OPW-1:0] p_o
);
  import dsp_fixed_pkg::*;

  logic signed [2*OPW-1:0] ax;
  logic signed [2*OPW-1:0] bx;
  logic signed [2*OPW-1:0] prod;

  always_comb begin
    ax   = (2*OPW)'(a_i);
    bx   = (2*OPW)'(b_i);
    prod = ax * bx;
    p_o  = (2*OPW)'(fx_trunc_div(wide_t'(prod), SH));
  end

endmodule

// File: rtl/overdrive_seq.sv
// Sequenced overdrive: pre-gain, cubic soft clip (x^3+3x)/4, clamp to +-ONE/2.
// Ports: clk, rst (sync, active-high), bus (overdrive_seq_if.slave).
module overdrive_seq #(
  parameter int DATA_W = 32,
  parameter int GAIN_W = 16,
  parameter int FRAC   = 12,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  overdrive_seq_if.slave bus
);
  import dsp_fixed_pkg::*;

  localparam int OPW = DATA_W + 1;
  localparam int PW  = 2 * OPW;

  localparam logic signed [PW-1:0] HI = PW'(ONE);
  localparam logic signed [PW-1:0] LO = -HI;
  localparam logic signed [DATA_W-1:0] CL_P = DATA_W'(CLAMP_OUT);
  localparam logic signed [DATA_W-1:0] CL_N = -CL_P;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] smp_q, smp_d;
  logic signed [DATA_W-1:0] g_q, g_d;
  logic signed [DATA_W-1:0] s_q, s_d;
  logic signed [DATA_W-1:0] c_q, c_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic [GAIN_W-1:0]        gain_q, gain_d;
  logic                     clip_q, clip_d;
  logic                     rdy_q, rdy_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic signed [OPW-1:0] ma, mb;
  logic signed [PW-1:0]  mp;
  logic signed [PW-1:0]  sum;
  logic                  acc;
  logic                  inc;

  fx_mult #(.OPW(OPW), .SH(FRAC)) u_mult (
    .a_i (ma),
    .b_i (mb),
    .p_o (mp)
  );

  always_comb begin
    ma = '0;
    mb = '0;
    unique case (state_q)
      GAIN: begin
        ma = OPW'(smp_q);
        mb = OPW'(gain_q);
      end
      SQ: begin
        ma = OPW'(g_q);
        mb = OPW'(g_q);
      end
      CUBE: begin
        ma = OPW'(s_q);
        mb = OPW'(g_q);
      end
      default: ;
    endcase
  end

  assign sum = PW'(c_q) + PW'(g_q) + PW'(g_q) + PW'(g_q);

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    gain_d  = gain_q;
    g_d     = g_q;
    s_d     = s_q;
    c_d     = c_q;
    out_d   = out_q;
    clip_d  = clip_q;
    inc     = 1'b0;
    acc     = rdy_q && bus.in_valid && (state_q == IDLE);
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          smp_d  = bus.in_sample;
          gain_d = bus.gain;
          if (bus.bypass) begin
            out_d   = bus.in_sample;
            clip_d  = 1'b0;
            state_d = OUT;
          end else begin
            state_d = GAIN;
          end
        end
      end
      GAIN: begin
        // Range test on the full-width product, before any narrowing.
        if (mp <= LO) begin
          out_d   = CL_N;
          clip_d  = 1'b1;
          inc     = 1'b1;
          state_d = OUT;
        end else if (mp >= HI) begin
          out_d   = CL_P;
          clip_d  = 1'b1;
          inc     = 1'b1;
          state_d = OUT;
        end else begin
          g_d     = DATA_W'(mp);
          state_d = SQ;
        end
      end
      SQ: begin
        s_d     = DATA_W'(mp);
        state_d = CUBE;
      end
      CUBE: begin
        c_d     = DATA_W'(mp);
        state_d = SUM;
      end
      SUM: begin
        out_d   = DATA_W'(fx_trunc_div(wide_t'(sum), 2));
        clip_d  = 1'b0;
        state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
    cnt_d = cnt_q;
    if (bus.clip_clr) cnt_d = '0;
    else if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      smp_q   <= '0;
      gain_q  <= '0;
      g_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      out_q   <= '0;
      clip_q  <= 1'b0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      gain_q  <= gain_d;
      g_q     <= g_d;
      s_q     <= s_d;
      c_q     <= c_d;
      out_q   <= out_d;
      clip_q  <= clip_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready   = rdy_q;
  assign bus.out_valid  = (state_q == OUT);
  assign bus.out_sample = out_q;
  assign bus.clipped    = clip_q;
  assign bus.clip_count = cnt_q;

endmodule

// File: tb/tb_overdrive_seq.sv
// Self-checking bench for overdrive_seq: directed cases plus random traffic
// compared every cycle against a latency/arithmetic reference model.
module tb_overdrive_seq;

  localparam int    CW   = 8;
  localparam longint CMAX = (64'd1 << CW) - 1;

  typedef logic signed [63:0] v_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  overdrive_seq_if #(.DATA_W(32), .GAIN_W(16), .CNT_W(CW)) bus ();

  overdrive_seq #(
    .DATA_W (32),
    .GAIN_W (16),
    .FRAC   (12),
    .CNT_W  (CW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit rnd_on = 1'b0;

  task automatic check(input string nm, input v_t got, input v_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; '/' truncates toward zero.
  task automatic ref_od(input longint s, input longint gn, input bit byp,
                        output longint r, output bit c, output int lat);
    longint g, sq, cu;
    if (byp) begin
      r = s; c = 1'b0; lat = 1;
      return;
    end
    g = (s * gn) / 4096;
    if (g <= -4096) begin
      r = -2048; c = 1'b1; lat = 2;
    end else if (g >= 4096) begin
      r = 2048; c = 1'b1; lat = 2;
    end else begin
      sq  = (g * g) / 4096;
      cu  = (sq * g) / 4096;
      r   = (cu + 3 * g) / 4;
      c   = 1'b0;
      lat = 5;
    end
  endtask

  // Cycle model: counts down the latency of each accepted sample.
  bit     m_rdy = 1'b0;
  bit     m_valid = 1'b0;
  bit     m_clip = 1'b0;
  bit     m_inc;
  int     m_wait = 0;
  longint m_res = 0;
  longint m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_rdy = 1'b0; m_valid = 1'b0; m_wait = 0; m_cnt = 0;
    end else begin
      m_inc = 1'b0;
      if (m_valid) begin
        if (bus.out_ready) begin
          m_valid = 1'b0; m_rdy = 1'b1;
        end
      end else if (m_wait == 0) begin
        if (m_rdy && bus.in_valid) begin
          ref_od(longint'(bus.in_sample), longint'(bus.gain), bus.bypass,
                 m_res, m_clip, m_wait);
          m_rdy = 1'b0;
        end else begin
          m_rdy = 1'b1;
        end
      end
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1'b1; m_inc = m_clip;
        end
      end
      if (bus.clip_clr) m_cnt = 0;
      else if (m_inc && m_cnt < CMAX) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready", bus.in_ready, m_rdy);
      check("out_valid", bus.out_valid, m_valid);
      check("clip_count", bus.clip_count, m_cnt);
      if (m_valid) begin
        check("out_sample", bus.out_sample, m_res);
        check("clipped", bus.clipped, m_clip);
      end
    end
  end

  task automatic wait_rdy();
    int n = 0;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk); n++;
    end
    if (!bus.in_ready) check("rdy_timeout", bus.in_ready, 1);
  endtask

  task automatic xact(input int s, input int gn, input bit byp,
                      input int hold, input longint er, input bit ec,
                      input int el);
    int n;
    bus.in_sample = s;
    bus.gain      = 16'(gn);
    bus.bypass    = byp;
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    wait_rdy();
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_sample = $urandom;
    bus.gain      = 16'($urandom);
    bus.bypass    = 1'($urandom);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!bus.out_valid && n < 20);
    check("latency", n, el);
    check("result", bus.out_sample, er);
    check("result_clip", bus.clipped, ec);
    repeat (hold) begin
      check("hold_sample", bus.out_sample, er);
      check("hold_rdy", bus.in_ready, 0);
      check("hold_valid", bus.out_valid, 1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rdy_return", bus.in_ready, 1);
    check("valid_drop", bus.out_valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint r;
    bit     c;
    int     l;
    bit     seen;
    int     k;

    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.gain      = '0;
    bus.bypass    = 1'b0;
    bus.out_ready = 1'b1;
    bus.clip_clr  = 1'b0;

    ref_od(2048, 4096, 0, r, c, l);
    check("model_2048", r, 1664);
    check("model_2048_lat", l, 5);
    ref_od(-2048, 4096, 0, r, c, l);
    check("model_m2048", r, -1664);
    ref_od(-1, 4096, 0, r, c, l);
    check("model_m1", r, 0);
    ref_od(3, 4096, 0, r, c, l);
    check("model_3", r, 2);
    ref_od(64'sh4000_0000, 8192, 0, r, c, l);
    check("model_wide", r, 2048);
    check("model_wide_clip", c, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sample", bus.out_sample, 0);
    check("rst_clipped", bus.clipped, 0);
    check("rst_clip_count", bus.clip_count, 0);
    cmp_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rdy_after_rst", bus.in_ready, 1);

    xact(2048, 4096, 0, 0, 1664, 0, 5);
    xact(-2048, 4096, 0, 0, -1664, 0, 5);
    xact(-1, 4096, 0, 0, 0, 0, 5);
    xact(3, 4096, 0, 0, 2, 0, 5);
    xact(4096, 4096, 0, 0, 2048, 1, 2);
    xact(-5000, 4096, 0, 0, -2048, 1, 2);
    check("count_two", bus.clip_count, 2);
    xact(1024, 8192, 0, 0, 1664, 0, 5);
    xact(32'h4000_0000, 8192, 0, 0, 2048, 1, 2);
    xact(12345, 4096, 1, 3, 12345, 0, 1);

    // Reset while the sample sits in CUBE.
    bus.in_sample = 2048;
    bus.gain      = 16'd4096;
    bus.bypass    = 1'b0;
    bus.in_valid  = 1'b1;
    wait_rdy();
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_mid_valid", seen, 0);
    check("rst_mid_count", bus.clip_count, 0);

    // Back-to-back clamped samples to saturate the counter.
    bus.in_sample = 4096;
    bus.gain      = 16'd4096;
    bus.bypass    = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    repeat (3 * (int'(CMAX) + 20)) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("sat_count", bus.clip_count, CMAX);

    // Clear coinciding with a clamped result.
    bus.in_sample = -9000;
    bus.in_valid  = 1'b1;
    wait_rdy();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.clip_clr = 1'b1;
    @(posedge clk); #1 bus.clip_clr = 1'b0;
    @(negedge clk);
    check("clr_count", bus.clip_count, 0);
    check("clr_clipped", bus.clipped, 1);
    check("clr_valid", bus.out_valid, 1);
    @(negedge clk);

    rnd_on = 1'b1;
    fork
      begin
        for (int t = 0; t < 200; t++) begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
          k = int'($urandom % 8);
          bus.bypass = (k == 0);
          bus.gain   = (k == 1) ? 16'($urandom) : 16'($urandom_range(0, 9000));
          if (k <= 1) bus.in_sample = $urandom;
          else bus.in_sample = int'($urandom_range(0, 12000)) - 6000;
          bus.in_valid = 1'b1;
          wait_rdy();
          @(posedge clk); #1;
          bus.in_valid  = 1'b0;
          bus.in_sample = $urandom;
          bus.gain      = 16'($urandom);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom % 4) != 0;
          bus.clip_clr  = ($urandom % 32) == 0;
        end
        bus.out_ready = 1'b1;
        bus.clip_clr  = 1'b0;
      end
    join
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
